// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and grant owner IDs.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    LOCK = 2'd1,
    COOL = 2'd2
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: req[0]=CPU, req[1]=DBG; on a tie the port not served last wins.
module rr_pick2
  import dmem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // pick a single winner from the request pair
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == OWN_DBG) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter between the CPU and a debug/loader port, with
// round-robin sharing, watchdog-bounded debug lock, and one-cycle read-data return.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  arb_state_t       state_r, state_s;
  logic [CNT_W-1:0] lock_cnt_r, lock_cnt_s;
  logic             last_owner_r;
  logic             rsp_valid_r, rsp_owner_r, rsp_we_r;
  logic [1:0]       rr_gnt_s;

  rr_pick2 u_pick (
    .req  ({dbg_req, cpu_req}),
    .last (last_owner_r),
    .gnt  (rr_gnt_s)
  );

  // grant generation; LOCK hands the port to the debug side exclusively
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end else if (state_r == LOCK) begin
      cpu_gnt = 1'b0;
      dbg_gnt = dbg_req;
    end else begin
      cpu_gnt = rr_gnt_s[0];
      dbg_gnt = rr_gnt_s[1];
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;

  // memory request mux from the granted port
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // next state and watchdog count; a lock drop at the limit wins over cooling
  always_comb begin
    state_s    = state_r;
    lock_cnt_s = lock_cnt_r;
    case (state_r)
      ARB: begin
        if (dbg_gnt && dbg_lock) begin
          state_s    = LOCK;
          lock_cnt_s = CNT_ONE;
        end else begin
          state_s    = ARB;
          lock_cnt_s = '0;
        end
      end
      LOCK: begin
        if (lock_cnt_r != CNT_MAX) begin
          lock_cnt_s = lock_cnt_r + CNT_ONE;
        end else begin
          lock_cnt_s = lock_cnt_r;
        end
        if (!dbg_lock) begin
          state_s    = ARB;
          lock_cnt_s = '0;
        end else if (lock_cnt_r == CNT_MAX) begin
          state_s = COOL;
        end else begin
          state_s = LOCK;
        end
      end
      COOL: begin
        lock_cnt_s = '0;
        if (cpu_gnt || !cpu_req) begin
          state_s = ARB;
        end else begin
          state_s = COOL;
        end
      end
      default: begin
        state_s    = ARB;
        lock_cnt_s = '0;
      end
    endcase
  end

  // FSM, watchdog and round-robin history registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ARB;
      lock_cnt_r   <= '0;
      last_owner_r <= OWN_DBG;
    end else begin
      state_r    <= state_s;
      lock_cnt_r <= lock_cnt_s;
      if (cpu_gnt) begin
        last_owner_r <= OWN_CPU;
      end else if (dbg_gnt) begin
        last_owner_r <= OWN_DBG;
      end else begin
        last_owner_r <= last_owner_r;
      end
    end
  end

  // remember who owns the access in flight so the return goes to the right port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_owner_r <= OWN_CPU;
      rsp_we_r    <= 1'b0;
    end else begin
      rsp_valid_r <= mem_en;
      rsp_owner_r <= dbg_gnt ? OWN_DBG : OWN_CPU;
      rsp_we_r    <= mem_we;
    end
  end

  assign cpu_rvalid = rsp_valid_r & (rsp_owner_r == OWN_CPU);
  assign dbg_rvalid = rsp_valid_r & (rsp_owner_r == OWN_DBG);
  assign cpu_rdata  = (cpu_rvalid && !rsp_we_r) ? mem_rdata : '0;
  assign dbg_rdata  = (dbg_rvalid && !rsp_we_r) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized self-checking bench for dmem_port_arbiter against a transaction-level model.
module tb_dmem_port_arbiter;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_wdata = '0;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // the physical single-port RAM attached to the arbiter
  logic [DATA_W-1:0] mem_arr [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model state, kept in plain transaction terms
  logic [DATA_W-1:0] ref_mem [64];
  bit                m_locked, m_cooling, m_last_dbg;
  int                m_locked_cycles;
  bit                p_valid, p_dbg;
  logic [DATA_W-1:0] p_data;
  bit                hold_reset;
  bit                last_gc, last_gd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked        = 1'b0;
    m_cooling       = 1'b0;
    m_last_dbg      = 1'b1;
    m_locked_cycles = 0;
    p_valid         = 1'b0;
    p_dbg           = 1'b0;
    p_data          = '0;
  endtask

  task automatic cycle(input bit cr, input bit cw, input logic [5:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dw, input logic [5:0] da, input logic [31:0] dd,
                       input bit lk);
    bit          gc, gd;
    logic [39:0] em;
    logic [32:0] ecr, edr;
    @(negedge clk);
    reset = hold_reset;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock = lk;
    #1;
    if (reset) begin
      model_reset();
      gc = 1'b0; gd = 1'b0;
    end else if (m_locked) begin
      gc = 1'b0; gd = dr;
    end else if (cr && dr) begin
      gc = m_last_dbg; gd = !m_last_dbg;
    end else begin
      gc = cr; gd = dr;
    end
    if (gc)      em = {1'b1, cw, ca, cd};
    else if (gd) em = {1'b1, dw, da, dd};
    else         em = 40'd0;
    ecr = (p_valid && !p_dbg) ? {1'b1, p_data} : 33'd0;
    edr = (p_valid &&  p_dbg) ? {1'b1, p_data} : 33'd0;
    check_eq("grant", {61'd0, cpu_gnt, dbg_gnt, cpu_stall}, {61'd0, gc, gd, cr && !gc && !reset});
    check_eq("mem_port", {24'd0, mem_en, mem_we, mem_addr, mem_wdata}, {24'd0, em});
    check_eq("cpu_rsp", {31'd0, cpu_rvalid, cpu_rdata}, {31'd0, ecr});
    check_eq("dbg_rsp", {31'd0, dbg_rvalid, dbg_rdata}, {31'd0, edr});
    last_gc = gc;
    last_gd = gd;
    if (!reset) begin
      p_valid = gc || gd;
      p_dbg   = gd;
      if (gc || gd) begin
        m_last_dbg = gd;
        if (em[38]) begin
          p_data = '0;
          ref_mem[em[37:32]] = em[31:0];
        end else begin
          p_data = ref_mem[em[37:32]];
        end
      end
      if (m_locked) begin
        if (!lk) m_locked = 1'b0;
        else if (m_locked_cycles == LOCK_MAX) begin
          m_locked  = 1'b0;
          m_cooling = 1'b1;
        end else m_locked_cycles++;
      end else if (m_cooling) begin
        if (gc || !cr) m_cooling = 1'b0;
      end else if (gd && lk) begin
        m_locked        = 1'b1;
        m_locked_cycles = 1;
      end
    end
  endtask

  bit                c_req, c_we, d_req, d_we;
  logic [5:0]        c_addr, d_addr;
  logic [31:0]       c_wd, d_wd;
  int                lock_left;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    model_reset();
    hold_reset = 1'b1;

    // outputs quiet during reset whatever the inputs do
    repeat (2) cycle(1'b1, 1'b1, 6'd9, $urandom, 1'b1, 1'b0, 6'd4, $urandom, 1'b1);
    hold_reset = 1'b0;

    // CPU read of the preloaded word
    cycle(1'b1, 1'b0, 6'd5, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
    check_eq("deadbeef", {32'd0, cpu_rdata}, {32'd0, 32'hDEADBEEF});

    // both ports hammering: strict alternation
    repeat (6) cycle(1'b1, 1'b0, 6'($urandom), 32'd0, 1'b1, 1'b0, 6'($urandom), 32'd0, 1'b0);

    // locked debug write while the CPU waits on the same word
    cycle(1'b1, 1'b0, 6'd1, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 6'd3, 32'd0, 1'b1, 1'b1, 6'd3, 32'h12345678, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, 6'd3, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 6'd3, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 6'd3, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
    check_eq("lock_wr_rd", {32'd0, cpu_rdata}, {32'd0, 32'h12345678});

    // lock held far past the watchdog limit
    repeat (40) cycle(1'b1, 1'b0, 6'($urandom), 32'd0, 1'b1, 1'b0, 6'($urandom), 32'd0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);

    // reset lands right behind a debug read grant
    cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd7, 32'd0, 1'b0);
    @(posedge clk);
    reset = 1'b1;
    hold_reset = 1'b1;
    #1;
    check_eq("rst_rvalid", {63'd0, dbg_rvalid}, 64'd0);
    repeat (2) cycle(1'b1, 1'b0, 6'd2, 32'd0, 1'b1, 1'b1, 6'd2, $urandom, 1'b1);
    hold_reset = 1'b0;
    cycle(1'b1, 1'b0, 6'd8, 32'd0, 1'b1, 1'b0, 6'd9, 32'd0, 1'b0);
    check_eq("first_tie", {63'd0, cpu_gnt}, 64'd1);

    // CPU write acknowledgement
    cycle(1'b1, 1'b1, 6'd10, 32'hCAFEF00D, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);

    // randomized traffic with hold-until-granted requesters and lock bursts
    last_gc = 1'b1; last_gd = 1'b1;
    c_req = 1'b0; d_req = 1'b0; lock_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!c_req || last_gc) begin
        c_req  = ($urandom_range(0, 9) < 6);
        c_we   = 1'($urandom_range(0, 1));
        c_addr = 6'($urandom_range(0, 63));
        c_wd   = $urandom;
      end
      if (!d_req || last_gd) begin
        d_req  = ($urandom_range(0, 9) < 5);
        d_we   = 1'($urandom_range(0, 1));
        d_addr = 6'($urandom_range(0, 63));
        d_wd   = $urandom;
      end
      if (lock_left > 0) lock_left--;
      else if ($urandom_range(0, 29) == 0) lock_left = $urandom_range(1, 30);
      cycle(c_req, c_we, c_addr, c_wd, d_req, d_we, d_addr, d_wd, lock_left > 0);
    end
    cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single-port data memory between two requesters: the CPU load/store path and a debug/loader port (UART loader, LED scanner). Round-robin arbitration serves ordinary accesses. The debug port can lock the memory for bursts, bounded by a watchdog. The block drives a stall to the CPU while the CPU's request is not granted and returns read data with fixed one-cycle latency.

## Interface
Parameters:
- ADDR_W, 6, word address width (64-word memory)
- DATA_W, 32, data width
- LOCK_MAX, 16, maximum consecutive cycles in LOCK before forced release (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  completion/read-data strobe for CPU
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port request, same meaning as the CPU inputs
- dbg_lock  in  1  request exclusive ownership while held
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  debug port responses
- mem_en, mem_we  out  1  memory enable/write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en

## Operation
- States: ARB, LOCK, COOL.
- ARB:
  - Single requester: that requester is granted.
  - Both requesting: the one not served last is granted. The last_owner register resets to DBG, so the CPU wins the first tie.
  - last_owner updates on every grant.
- ARB→LOCK: at the edge where dbg_gnt=1 and dbg_lock=1. lock_cnt loads 1.
- LOCK:
  - cpu_gnt=0; dbg_gnt=dbg_req.
  - lock_cnt increments every cycle, saturating at LOCK_MAX.
  - dbg_lock=0 → ARB at the next edge.
  - lock_cnt==LOCK_MAX with dbg_lock still 1 → COOL.
- COOL:
  - Behaves as ARB, except that dbg_lock is ignored and no LOCK entry is allowed.
  - → ARB on the edge after a cpu_gnt, or on any edge with cpu_req=0.
- Grants are combinational from the request inputs and state. Requesters hold req/we/addr/wdata stable until their gnt is sampled high.
- Memory mux: mem_en = cpu_gnt|dbg_gnt; mem_we, mem_addr and mem_wdata come from the granted port; all are 0 when nothing is granted.
- Completion: the owner of each grant is registered.
  - The next cycle, that owner's rvalid=1 and its rdata=mem_rdata.
  - For writes, rvalid=1 as an acknowledgement and rdata=0.
  - The non-owner's rdata=0.
- At most one grant per cycle. Back-to-back grants are allowed, one access per cycle of throughput.
- A request that is dropped before it is granted is simply not served.

## Timing
- Reset values:
  - State: ARB, lock_cnt=0, last_owner=DBG.
  - Outputs: cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0.
  - Grants, cpu_stall and all mem_* outputs are 0 while reset is asserted, regardless of the inputs.
- Latency: grant in cycle N, rvalid and rdata in cycle N+1.
- Reset asserted mid-access: any pending rvalid is discarded, and the state returns to ARB immediately.
- A simultaneous dbg_lock drop and lock_cnt==LOCK_MAX in LOCK goes to ARB, not COOL.
- A LOCK entry needs dbg_gnt in ARB, so the first locked access is itself granted through round-robin.

## Structure
- Shared package constants:
  - The state encoding: ARB=2'd0, LOCK=2'd1, COOL=2'd2.
  - The owner encoding: OWN_CPU=1'b0, OWN_DBG=1'b1.
- Optional sub-module rr_pick2: a pure combinational two-way round-robin picker taking req[1:0] and last, returning gnt[1:0]. All sequential logic stays in dmem_port_arbiter.

## Test plan
- After reset, CPU read at addr 5 with the memory word = 32'hDEADBEEF: cpu_gnt=1 in the same cycle, cpu_rvalid=1 and cpu_rdata=32'hDEADBEEF the next cycle, cpu_stall=0.
- Both ports continuously requesting for 6 cycles: grants alternate CPU, DBG, CPU, DBG, CPU, DBG, and each rvalid goes to the correct port.
- DBG writes 32'h12345678 to addr 3 with lock held 5 cycles while the CPU requests: the CPU is stalled 5 cycles after the first DBG grant, then cpu_gnt=1 after the lock drops, and a CPU read of addr 3 returns 32'h12345678.
- LOCK_MAX=16, dbg_lock held 40 cycles with cpu_req=1: COOL is entered after 16 locked cycles, the CPU is granted within 2 cycles, and LOCK is re-entered only after that CPU grant.
- Reset asserted one cycle after a DBG read grant: dbg_rvalid stays 0, all outputs are 0, and the first tie after reset goes to the CPU.
- Write completion: cpu_we=1 → cpu_rvalid=1 and cpu_rdata=0 the next cycle, and mem_we was 1 only in the grant cycle.
